// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants and the receiver state encoding.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int N_CYCLES_DEFAULT = 868;  // 100 MHz / 115200 baud

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BREAK = 5'b10000
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset value.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled, LSB-first, with a one-entry valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int N_CYCLES = N_CYCLES_DEFAULT  // clock cycles per bit, at least 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CW = $clog2(N_CYCLES);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_LOAD = CW'(N_CYCLES / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(N_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  rx_state_t     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          rx_s, tick, deliver, ferr;

  sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign tick = (cnt == '0);

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shift_nxt = shift;
    deliver   = 1'b0;
    ferr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          cnt_nxt   = HALF_LOAD;
          state_nxt = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_nxt = cnt - CW'(1);
        end else if (!rx_s) begin
          cnt_nxt   = FULL_LOAD;
          idx_nxt   = '0;
          state_nxt = DATA;
        end else begin
          state_nxt = IDLE;  // line went high again before mid-start: a glitch
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          shift_nxt = {rx_s, shift[7:1]};
          cnt_nxt   = FULL_LOAD;
          idx_nxt   = idx + IW'(1);
          if (idx == LAST_IDX) state_nxt = STOP;
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_nxt = cnt - CW'(1);
        end else if (rx_s) begin
          deliver   = 1'b1;
          state_nxt = IDLE;  // leaving at mid-stop lets the next start edge follow without a gap
        end else begin
          ferr      = 1'b1;
          state_nxt = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      shift <= shift_nxt;
    end
  end

  // Holding register: newest byte wins; a delivery into an unaccepted byte reports overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= 1'b0;
      if (deliver) begin
        data    <= shift;
        valid   <= 1'b1;
        overrun <= valid && !ready;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 cycles per bit, driving rx from an ideal time-based serialiser.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int  N      = 16;
  localparam real BIT_NS = 160.0;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  uart_rx #(.N_CYCLES(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // Monitor: records handshakes, valid rises and pulses, sampled on the falling edge.
  int         cyc = 0;
  int         start_cyc, rise_cyc, fe_cnt, ov_cnt, both_cnt, vrun, last_vrun;
  logic [7:0] ov_data;
  logic       valid_d = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] rise_q[$];

  always @(posedge clock) cyc = cyc + 1;

  always @(negedge clock) begin
    if (valid && ready) rx_q.push_back(data);
    if (valid && !valid_d) begin
      rise_cyc = cyc;
      rise_q.push_back(data);
    end
    if (valid) vrun = vrun + 1;
    if (!valid && valid_d) last_vrun = vrun;
    if (!valid) vrun = 0;
    if (frame_err) fe_cnt = fe_cnt + 1;
    if (overrun) begin
      ov_cnt  = ov_cnt + 1;
      ov_data = data;
    end
    if (frame_err && overrun) both_cnt = both_cnt + 1;
    valid_d = valid;
  end

  task automatic clear_mon();
    rx_q.delete();
    rise_q.delete();
    rise_cyc  = -1;
    fe_cnt    = 0;
    ov_cnt    = 0;
    both_cnt  = 0;
    vrun      = 0;
    last_vrun = -1;
  endtask

  task automatic align();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bits(input int bits);
    #(BIT_NS * bits);
  endtask

  task automatic send_frame(input logic [7:0] b, input real bit_ns, input logic stop_val,
                            input int stop_len);
    rx = 1'b0;
    start_cyc = cyc;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_val;
    #(bit_ns * stop_len);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx    = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", data); end
    vectors++;
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    vectors++;
    if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    vectors++;
    if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b1;
    repeat (4) @(posedge clock);
  endtask

  task automatic test_single();
    int lat;
    clear_mon();
    ready = 1'b1;
    align();
    send_frame(8'hA5, BIT_NS, 1'b1, 1);
    idle_bits(2);
    lat = rise_cyc - start_cyc;
    vectors++;
    if (rx_q.size() !== 1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", rx_q.size()); end
    vectors++;
    if ((rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'hA5) begin
      miscompares++; $display("FAIL single_data: got %h expected a5", rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
    vectors++;
    if (last_vrun !== 1) begin miscompares++; $display("FAIL single_valid_width: got %0d expected 1", last_vrun); end
    vectors++;
    if (lat < 155 || lat > 156) begin miscompares++; $display("FAIL single_latency: got %0d expected 155..156", lat); end
    vectors++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      miscompares++; $display("FAIL single_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    ready = 1'b1;
    align();
    rx = 1'b0;
    #40;
    rx = 1'b1;
    idle_bits(2);
    vectors++;
    if (rise_q.size() !== 0 || fe_cnt !== 0) begin
      miscompares++; $display("FAIL glitch_quiet: got valids=%0d fe=%0d expected 0 0", rise_q.size(), fe_cnt);
    end
    send_frame(8'h3C, BIT_NS, 1'b1, 1);
    idle_bits(2);
    vectors++;
    if (rx_q.size() !== 1 || (rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'h3C) begin
      miscompares++;
      $display("FAIL glitch_next_frame: got n=%0d byte=%h expected n=1 byte=3c", rx_q.size(),
               rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_frame_error();
    clear_mon();
    ready = 1'b1;
    align();
    send_frame(8'h81, BIT_NS, 1'b0, 2);
    idle_bits(2);
    send_frame(8'h55, BIT_NS, 1'b1, 1);
    idle_bits(2);
    vectors++;
    if (fe_cnt !== 1) begin miscompares++; $display("FAIL ferr_pulse_count: got %0d expected 1", fe_cnt); end
    vectors++;
    if (rise_q.size() !== 1 || (rise_q.size() > 0 ? rise_q[0] : 8'hxx) !== 8'h55) begin
      miscompares++;
      $display("FAIL ferr_next_valid: got n=%0d byte=%h expected n=1 byte=55", rise_q.size(),
               rise_q.size() > 0 ? rise_q[0] : 8'hxx);
    end
    vectors++;
    if (ov_cnt !== 0) begin miscompares++; $display("FAIL ferr_overrun: got %0d expected 0", ov_cnt); end
  endtask

  task automatic test_stream();
    clear_mon();
    ready = 1'b1;
    align();
    for (int i = 0; i < 16; i++) send_frame(8'(i), (i < 8) ? BIT_NS * 1.02 : BIT_NS * 0.98, 1'b1, 1);
    idle_bits(2);
    vectors++;
    if (rx_q.size() !== 16) begin miscompares++; $display("FAIL stream_count: got %0d expected 16", rx_q.size()); end
    for (int i = 0; i < 16; i++) begin
      vectors++;
      if ((i < rx_q.size() ? rx_q[i] : 8'hxx) !== 8'(i)) begin
        miscompares++;
        $display("FAIL stream_byte[%0d]: got %h expected %h", i, i < rx_q.size() ? rx_q[i] : 8'hxx, 8'(i));
      end
    end
    vectors++;
    if (fe_cnt !== 0 || ov_cnt !== 0) begin
      miscompares++; $display("FAIL stream_errors: got fe=%0d ov=%0d expected 0 0", fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    ready = 1'b0;
    align();
    send_frame(8'h12, BIT_NS, 1'b1, 1);
    send_frame(8'h34, BIT_NS, 1'b1, 1);
    idle_bits(2);
    vectors++;
    if (rise_q.size() !== 1 || (rise_q.size() > 0 ? rise_q[0] : 8'hxx) !== 8'h12) begin
      miscompares++;
      $display("FAIL b2b_first: got n=%0d byte=%h expected n=1 byte=12", rise_q.size(),
               rise_q.size() > 0 ? rise_q[0] : 8'hxx);
    end
    vectors++;
    if (ov_cnt !== 1 || ov_data !== 8'h34) begin
      miscompares++; $display("FAIL b2b_overrun: got n=%0d data=%h expected n=1 data=34", ov_cnt, ov_data);
    end
    vectors++;
    if (valid !== 1'b1 || data !== 8'h34) begin
      miscompares++; $display("FAIL b2b_held: got valid=%b data=%h expected 1 34", valid, data);
    end
    vectors++;
    if (both_cnt !== 0) begin miscompares++; $display("FAIL b2b_both_pulses: got %0d expected 0", both_cnt); end
    align();
    ready = 1'b1;
    @(negedge clock);
    vectors++;
    if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid_before_accept: got %b expected 1", valid); end
    @(negedge clock);
    vectors++;
    if (valid !== 1'b0 || data !== 8'h34) begin
      miscompares++; $display("FAIL b2b_after_accept: got valid=%b data=%h expected 0 34", valid, data);
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    ready = 1'b1;
    align();
    fork
      send_frame(8'hF0, BIT_NS, 1'b1, 1);
      begin
        repeat (72) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          miscompares++;
          $display("FAIL midreset_outputs: got data=%h valid=%b fe=%b ov=%b expected 00 0 0 0",
                   data, valid, frame_err, overrun);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
      end
    join
    idle_bits(2);
    vectors++;
    if (rise_q.size() !== 0 || fe_cnt !== 0) begin
      miscompares++; $display("FAIL midreset_aborted: got valids=%0d fe=%0d expected 0 0", rise_q.size(), fe_cnt);
    end
    send_frame(8'h0F, BIT_NS, 1'b1, 1);
    idle_bits(2);
    vectors++;
    if (rx_q.size() !== 1 || (rx_q.size() > 0 ? rx_q[0] : 8'hxx) !== 8'h0F) begin
      miscompares++;
      $display("FAIL midreset_next_frame: got n=%0d byte=%h expected n=1 byte=0f", rx_q.size(),
               rx_q.size() > 0 ? rx_q[0] : 8'hxx);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_glitch();
    test_frame_error();
    test_stream();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
